matrix_loader: RTL and testbench
================================

MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, element width in bits.
REQ-002 The block SHALL have parameter DIM, default 16, matrix side length (power of two, 2..16).
REQ-003 The block SHALL have derived parameter ADDR_W, default 8, equal to 2*log2(DIM) (address = {row, col}).
REQ-004 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset_n  input  1  reset; synchronous, active-low.
REQ-006 The block SHALL have port start  input  1  request to begin loading a new frame.
REQ-007 The block SHALL have port in_valid  input  1  upstream element valid.
REQ-008 The block SHALL have port in_data  input  DATA_W  upstream element value, row-major order.
REQ-009 The block SHALL have port in_ready  output  1  block accepts an element this cycle.
REQ-010 The block SHALL have port mem_we  output  1  write strobe to the matrix memory of the compute datapath.
REQ-011 The block SHALL have port mem_addr  output  ADDR_W  write address {row, col}.
REQ-012 The block SHALL have port mem_wdata  output  DATA_W  write data.
REQ-013 The block SHALL have port go_o  output  1  one-cycle start pulse to the even-product control unit.
REQ-014 The block SHALL have port calc_done  input  1  done level from the control unit; held high once asserted.
REQ-015 The block SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 States: IDLE, LOAD, FLUSH, KICK, WAIT.
REQ-017 IDLE->LOAD when start=1; row and col counters cleared to 0 on that transition.
REQ-018 in_ready SHALL be 1 only in LOAD; transfer occurs when in_valid=1 and in_ready=1.
REQ-019 Each transfer SHALL register mem_we=1, mem_addr={row,col}, mem_wdata=in_data for exactly the following cycle (write latency 1); mem_we=0 otherwise.
REQ-020 On a transfer, col increments; when col=DIM-1, col wraps to 0 and row increments.
REQ-021 A transfer at {row,col}={DIM-1,DIM-1} SHALL move LOAD->FLUSH; in_ready drops the next cycle; no counter wrap to row 0 is observable.
REQ-022 FLUSH->KICK unconditionally (last write committed); KICK asserts go_o=1 for exactly one cycle, then ->WAIT.
REQ-023 WAIT->IDLE on a rising edge of calc_done (calc_done=1 with previous-cycle calc_done=0); a level already high on entry to WAIT SHALL NOT release it.
REQ-024 in_valid=0 in LOAD: no write, counters hold; stall length unbounded.
REQ-025 start outside IDLE SHALL be ignored; start held high in IDLE after WAIT SHALL begin a new frame immediately.
REQ-026 in_data presented outside LOAD SHALL be ignored and never written.

Reset
REQ-027 reset_n=0 at a clock edge SHALL force state IDLE, row=0, col=0, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, go_o=0, busy=0, stored calc_done history=0.
REQ-028 Reset mid-LOAD SHALL discard the partial frame; no go_o is issued for it.

Configuration
REQ-029 Macro MATRIX_LOADER_EVEN_CNT_EN defined: output even_cnt (ADDR_W+1 bits) counts transferred elements with in_data[0]=0 in the current frame, cleared on IDLE->LOAD and on reset, stable from FLUSH until the next frame starts.
REQ-030 MATRIX_LOADER_EVEN_CNT_EN undefined: even_cnt port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-031 Full frame, in_valid always 1, data=0..255 -> 256 writes, mem_addr=data each write, go_o single pulse 2 cycles after last transfer.
REQ-032 in_valid toggling 1/0 every cycle -> 256 writes in 512 cycles, addresses contiguous, no duplicate or skipped address.
REQ-033 reset_n=0 after 100 transfers, then new start and full frame -> first write of new frame at mem_addr=0, exactly one go_o.
REQ-034 calc_done held 1 from before KICK -> block stays in WAIT; calc_done 0 then 1 -> IDLE next cycle, busy=0.
REQ-035 start pulsed during LOAD at transfer 50 -> ignored, frame completes normally with 256 writes.
REQ-036 With MATRIX_LOADER_EVEN_CNT_EN, data=0..255 -> even_cnt=128 at FLUSH; all-odd frame -> even_cnt=0.

Source files
------------

// File: rtl/matrix_loader.sv
// ---------------------------------------------------------------------------
// matrix_loader
//
// Purpose:
//   Accepts a DIM x DIM matrix as a row-major stream with a valid/ready
//   handshake. Each element is written into the compute datapath's matrix
//   memory one cycle after it is accepted. Once the last write is committed,
//   the block sends a one-cycle go_o pulse to the even-product control unit.
//   It then waits for a fresh rising edge of calc_done before returning to
//   idle.
//
// Ports:
//   clk        in   single clock, rising edge
//   reset_n    in   synchronous active-low reset
//   start      in   begin loading a new frame (honoured only in IDLE)
//   in_valid   in   upstream element valid
//   in_data    in   upstream element value [DATA_W]
//   in_ready   out  element accepted this cycle (high only in LOAD)
//   mem_we     out  matrix memory write strobe
//   mem_addr   out  write address {row, col} [ADDR_W]
//   mem_wdata  out  write data [DATA_W]
//   go_o       out  one-cycle start pulse to the control unit
//   calc_done  in   done level from the control unit
//   busy       out  high in any state other than IDLE
//   even_cnt   out  (MATRIX_LOADER_EVEN_CNT_EN only) number of accepted
//                   elements with an even value in the current frame
//
// Configuration macro: MATRIX_LOADER_EVEN_CNT_EN
// ---------------------------------------------------------------------------
module matrix_loader #(
  parameter int DATA_W = 8,
  parameter int DIM    = 16,
  parameter int ADDR_W = 2 * $clog2(DIM)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              go_o,
  input  logic              calc_done,
`ifdef MATRIX_LOADER_EVEN_CNT_EN
  output logic [ADDR_W:0]   even_cnt,
`endif
  output logic              busy
);

  localparam int            CW       = ADDR_W / 2;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIM - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_KICK  = 3'd3,
    ST_WAIT  = 3'd4
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_row;
  logic [CW-1:0]     r_col;
  logic              r_in_ready;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_go;
  logic              r_busy;
  logic              r_calc_prev;

  logic w_xfer;
  logic w_last;
  logic w_calc_rise;

  // r_in_ready is high exactly while in LOAD, so it doubles as the state qualifier.
  assign w_xfer      = in_valid & r_in_ready;
  assign w_last      = (r_row == CNT_LAST) && (r_col == CNT_LAST);
  // Release from WAIT requires a 0->1 transition, so a stale done level is ignored.
  assign w_calc_rise = calc_done & ~r_calc_prev;

  assign in_ready  = r_in_ready;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign go_o      = r_go;
  assign busy      = r_busy;

  // Loader FSM with its counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_row       <= '0;
      r_col       <= '0;
      r_in_ready  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_go        <= 1'b0;
      r_busy      <= 1'b0;
      r_calc_prev <= 1'b0;
    end else begin
      r_calc_prev <= calc_done;
      r_mem_we    <= 1'b0;
      r_go        <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_LOAD;
            r_row      <= '0;
            r_col      <= '0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (w_xfer) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= {r_row, r_col};
            r_mem_wdata <= in_data;
            // Counters stop at the last element; they are cleared on the next start.
            if (w_last) begin
              r_state    <= ST_FLUSH;
              r_in_ready <= 1'b0;
            end else if (r_col == CNT_LAST) begin
              r_col <= '0;
              r_row <= r_row + CNT_ONE;
            end else begin
              r_col <= r_col + CNT_ONE;
            end
          end
        end
        ST_FLUSH: begin
          // The final write is on the memory port this cycle; kick next cycle.
          r_state <= ST_KICK;
          r_go    <= 1'b1;
        end
        ST_KICK: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_calc_rise) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

`ifdef MATRIX_LOADER_EVEN_CNT_EN
  logic [ADDR_W:0] r_even_cnt;

  assign even_cnt = r_even_cnt;

  // Count accepted even-valued elements; the value freezes once LOAD is left.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_even_cnt <= '0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_even_cnt <= '0;
    end else if (w_xfer && !in_data[0]) begin
      r_even_cnt <= r_even_cnt + (ADDR_W + 1)'(1'b1);
    end
  end
`endif

endmodule

// File: tb/tb_matrix_loader.sv
module tb_matrix_loader;

  localparam int DATA_W = 8;
  localparam int DIM    = 16;
  localparam int ADDR_W = 8;
  localparam int NELEM  = DIM * DIM;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              go_o;
  logic              calc_done;
  logic              busy;
`ifdef MATRIX_LOADER_EVEN_CNT_EN
  logic [ADDR_W:0]   even_cnt;
`endif

  matrix_loader #(.DATA_W(DATA_W), .DIM(DIM)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .go_o      (go_o),
    .calc_done (calc_done),
`ifdef MATRIX_LOADER_EVEN_CNT_EN
    .even_cnt  (even_cnt),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One frame scenario: stimulus knobs plus the results it must produce.
  typedef struct {
    int valid_mode;   // 0: always valid, 1: toggle 1/0 each cycle
    int data_mode;    // 0: element index, 1: all odd, 2: random
    int start_at;     // element index at which start is pulsed mid-load (-1: none)
    bit calc_pre;     // calc_done already high before KICK
    bit restart;      // hold start high through the release into IDLE
    bit skip_start;   // frame already started by the previous restart
    int exp_writes;
    int exp_go;
    int exp_even;     // -1: take from the bench's running count
  } vec_t;

  vec_t vecs[4];

  logic [ADDR_W+DATA_W-1:0] sb_q[$];
  int n_chk;
  int n_fail;
  int n_writes;
  int n_go;
  int tb_idx;
  int even_m;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: record a handshake as an expected write, then check the write port.
  task automatic step();
    logic [ADDR_W+DATA_W-1:0] e;
    logic xfer;
    xfer = in_valid && in_ready;
    @(posedge clk);
    if (xfer) begin
      sb_q.push_back({tb_idx[ADDR_W-1:0], in_data});
      if (!in_data[0]) even_m++;
      tb_idx++;
    end
    #1;
    if (mem_we === 1'b1) begin
      n_writes++;
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %0d expected no write", mem_addr, mem_wdata);
      end else begin
        e = sb_q.pop_front();
        chk("wr_addr", int'(mem_addr), int'(e[ADDR_W+DATA_W-1:DATA_W]));
        chk("wr_data", int'(mem_wdata), int'(e[DATA_W-1:0]));
      end
    end
    if (go_o === 1'b1) n_go++;
  endtask

  task automatic check_reset_state();
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_mem_we", int'(mem_we), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_mem_wdata", int'(mem_wdata), 0);
    chk("rst_go", int'(go_o), 0);
`ifdef MATRIX_LOADER_EVEN_CNT_EN
    chk("rst_even_cnt", int'(even_cnt), 0);
`endif
  endtask

  task automatic run_frame(input vec_t v);
    int w0;
    int g0;
    int cyc;
    int exp_even;
    w0 = n_writes;
    g0 = n_go;
    tb_idx = 0;
    even_m = 0;
    if (!v.skip_start) begin
      start = 1'b1;
      step();
      start = 1'b0;
    end
    chk("load_in_ready", int'(in_ready), 1);
    chk("load_busy", int'(busy), 1);
    if (v.calc_pre) calc_done = 1'b1;
    cyc = 0;
    while (tb_idx < NELEM && cyc < 2000) begin
      in_valid = (v.valid_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      if (!in_valid) in_data = DATA_W'($urandom_range(0, 255));
      else if (v.data_mode == 0) in_data = DATA_W'(tb_idx);
      else if (v.data_mode == 1) in_data = DATA_W'(2 * tb_idx + 1);
      else in_data = DATA_W'($urandom_range(0, 255));
      start = (v.start_at >= 0 && tb_idx == v.start_at) ? 1'b1 : 1'b0;
      step();
      cyc++;
    end
    start = 1'b0;
    chk("frame_elements", tb_idx, NELEM);
    if (v.valid_mode == 0) chk("load_cycles", cyc, NELEM);
    else chk("load_cycles_le_512", int'(cyc <= 2 * NELEM), 1);
    // FLUSH: junk presented now must never be accepted.
    in_valid = 1'b1;
    in_data  = 8'hA5;
    chk("flush_in_ready", int'(in_ready), 0);
    chk("flush_go", int'(go_o), 0);
    chk("flush_busy", int'(busy), 1);
    exp_even = (v.exp_even >= 0) ? v.exp_even : even_m;
`ifdef MATRIX_LOADER_EVEN_CNT_EN
    chk("flush_even_cnt", int'(even_cnt), exp_even);
`endif
    step();
    chk("kick_go", int'(go_o), 1);
    step();
    chk("wait_go", int'(go_o), 0);
    for (int i = 0; i < 5; i++) step();
    chk("wait_hold_busy", int'(busy), 1);
`ifdef MATRIX_LOADER_EVEN_CNT_EN
    chk("wait_even_cnt", int'(even_cnt), exp_even);
`endif
    in_valid = 1'b0;
    if (v.calc_pre) begin
      calc_done = 1'b0;
      step();
      chk("calc_low_busy", int'(busy), 1);
    end
    if (v.restart) start = 1'b1;
    calc_done = 1'b1;
    step();
    chk("release_busy", int'(busy), 0);
    calc_done = 1'b0;
    if (v.restart) begin
      step();
      start = 1'b0;
      chk("restart_in_ready", int'(in_ready), 1);
      chk("restart_busy", int'(busy), 1);
    end
    chk("frame_writes", n_writes - w0, v.exp_writes);
    chk("frame_go", n_go - g0, v.exp_go);
    chk("sb_empty", sb_q.size(), 0);
    tb_idx = 0;
    even_m = 0;
  endtask

  initial begin
    int g0;
    n_chk = 0;
    n_fail = 0;
    n_writes = 0;
    n_go = 0;
    tb_idx = 0;
    even_m = 0;

    vecs[0] = '{0, 0, -1, 1'b0, 1'b0, 1'b0, NELEM, 1, 128};
    vecs[1] = '{1, 0, -1, 1'b1, 1'b0, 1'b0, NELEM, 1, 128};
    vecs[2] = '{0, 1, 50, 1'b0, 1'b1, 1'b0, NELEM, 1, 0};
    vecs[3] = '{1, 2, -1, 1'b0, 1'b0, 1'b1, NELEM, 1, -1};

    reset_n   = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h3C;
    calc_done = 1'b0;
    step();
    step();
    check_reset_state();
    reset_n = 1'b1;
    step();
    chk("idle_ignores_data", n_writes, 0);

    for (int i = 0; i < 4; i++) run_frame(vecs[i]);

    // Reset in the middle of a frame: partial data is dropped, no kick.
    g0 = n_go;
    tb_idx = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 400 && tb_idx < 100; i++) begin
      in_data = DATA_W'(8'hFF - tb_idx);
      step();
    end
    chk("partial_elements", tb_idx, 100);
    in_valid = 1'b0;
    reset_n = 1'b0;
    step();
    check_reset_state();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("partial_no_go", n_go - g0, 0);
    chk("partial_sb_empty", sb_q.size(), 0);
    chk("post_reset_idle", int'(busy), 0);
    tb_idx = 0;
    even_m = 0;
    run_frame(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
